sm_dbg_scan: RTL and testbench
==============================

// Module: sm_dbg_scan
// PURPOSE
//  Hardware state-dump sequencer for the schoolMIPS core debug ports. On start, walks
//  regAddr over the register file, then ramAddrB over data RAM, captures each
//  word, and streams {tag,data} out over a valid/ready link (UART/JTAG bridge).
//  Replaces the bench-only register/RAM dump with a synthesizable equivalent.
// PARAMETERS
//  REG_CNT  32  registers scanned, indices 0..REG_CNT-1 (index 0 returns PC on sm_cpu)
//  RAM_CNT  16  RAM words scanned, indices 0..RAM_CNT-1; 0 skips RAM phase
//  RD_LAT   1   cycles from address register update to data capture (1..3)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous reset, active-high
//  start      in   1   begin scan; sampled only in IDLE
//  busy       out  1   high from accepted start until done
//  done       out  1   1-cycle pulse after final output handshake
//  regAddr    out  5   to sm_cpu regAddr
//  regData    in   32  from sm_cpu regData
//  ramAddrB   out  5   to sm_cpu ramAddrB
//  ramDataB   in   32  from sm_cpu ramDataB
//  out_valid  out  1   output word valid
//  out_ready  in   1   sink accepts word
//  out_tag    out  7   {kind[1:0], index[4:0]}; kind 00=reg, 01=ram, 10=checksum
//  out_data   out  32  captured word
// BEHAVIOUR
//  - Clock clk; reset rst is synchronous and active-high. Reset: state IDLE,
//    regAddr=0, ramAddrB=0, busy=0, done=0, out_valid=0, out_tag=0, out_data=0.
//  - FSM: IDLE -> ADDR -> WAIT -> EMIT -> (ADDR | SUM | FIN) ; FIN -> IDLE.
//    IDLE: start=1 -> ADDR, busy=1, phase=REG, idx=0.
//    ADDR: drive idx onto regAddr (phase REG) or ramAddrB (phase RAM); 1 cycle.
//    WAIT: count RD_LAT cycles, then capture regData/ramDataB into out_data.
//    EMIT: out_valid=1; out_tag/out_data stable while out_valid && !out_ready.
//      On handshake: idx==last of phase? REG->RAM (idx=0) or RAM->SUM/FIN; else idx+1.
//    FIN: done=1 for one cycle, busy=0, next IDLE.
//  - Latency per word, zero backpressure: 1 (ADDR) + RD_LAT + 1 (EMIT) cycles.
//  - Unselected address port holds its last value (no glitching RF/RAM reads).
//  - start while busy: ignored. start in FIN cycle: ignored; accepted from IDLE.
//  - RAM_CNT=0: after last register handshake go directly to SUM/FIN.
//  - Reset mid-scan (incl. EMIT with out_valid=1): drop word, return to reset values.
//  - idx counter is 5 bits; REG_CNT, RAM_CNT <= 32 enforced by elaboration check.
// CONFIGURATION
//  SM_DBG_SCAN_CHKSUM_EN defined: after last data word enter SUM, emit one extra
//   word tag={2'b10,5'd0}, data = sum mod 2^32 of all emitted data words; then FIN.
//  Undefined: no SUM state, no accumulator; last data handshake -> FIN.
// STRUCTURE
//  - sm_dbg_scan.vh: `define state codes (IDLE/ADDR/WAIT/EMIT/SUM/FIN),
//    tag kind codes (SCAN_K_REG/RAM/SUM), tag width.
//  - Sub-module sm_dbg_outreg: output holding register (load, valid, ready,
//    tag, data); keeps stability rule out of the FSM.
// TESTING
//  - Reset: rst=1 2 cycles -> all outputs 0, busy=0; then start=1, RF[2]=5,
//    RF[3]=7 -> words tag 0x02 data 5, tag 0x03 data 7 in order, 48 words total.
//  - out_ready=1 always, RD_LAT=1 -> one word every 3 cycles; done pulse exactly
//    1 cycle after 48th handshake; busy falls same cycle.
//  - out_ready low 5 cycles during tag 0x21 (ram[1]=0x1234) -> out_valid held,
//    tag/data unchanged 5 cycles, no word skipped or duplicated.
//  - RAM_CNT=0 -> 32 reg words only, then done; start during busy -> no rescan.
//  - rst=1 in EMIT of word 10 -> out_valid=0 next cycle; fresh start rescans from tag 0x00.
//  - SM_DBG_SCAN_CHKSUM_EN, RF all 1, RAM all 2 -> final tag 0x40 data 32*1+16*2=64.

Source files
------------

// File: rtl/sm_dbg_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sm_dbg_scan_pkg                                                            |
// | Shared widths, FSM state codes and tag kinds for the state-dump sequencer. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package sm_dbg_scan_pkg;

   localparam int TAG_W  = 7;
   localparam int DATA_W = 32;
   localparam int IDX_W  = 5;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_EMIT = 3'd3;
   localparam logic [2:0] S_SUM  = 3'd4;
   localparam logic [2:0] S_FIN  = 3'd5;

   typedef enum logic [1:0] {
      K_REG = 2'b00,
      K_RAM = 2'b01,
      K_SUM = 2'b10
   } kind_e;

   function automatic logic [TAG_W-1:0] make_tag(input kind_e kind, input logic [IDX_W-1:0] idx);
      return {kind, idx};
   endfunction

endpackage
`default_nettype wire

// File: rtl/sm_dbg_scan_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sm_dbg_scan_if                                                             |
// | Valid/ready output link carrying {tag,data} words to the debug bridge.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface sm_dbg_scan_if;
   import sm_dbg_scan_pkg::*;

   logic              out_valid;
   logic              out_ready;
   logic [TAG_W-1:0]  out_tag;
   logic [DATA_W-1:0] out_data;

   modport master (output out_valid, output out_tag, output out_data, input  out_ready);
   modport slave  (input  out_valid, input  out_tag, input  out_data, output out_ready);
endinterface
`default_nettype wire

// File: rtl/sm_dbg_outreg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sm_dbg_outreg                                                              |
// | Output holding register: tag/data frozen while valid waits for ready.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sm_dbg_outreg
   import sm_dbg_scan_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [TAG_W-1:0]  load_tag,
   input  logic [DATA_W-1:0] load_data,
   sm_dbg_scan_if.master     bus
);

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_tag   <= '0;
         bus.out_data  <= '0;
      end else if (load) begin
         bus.out_valid <= 1'b1;
         bus.out_tag   <= load_tag;
         bus.out_data  <= load_data;
      end else if (bus.out_valid && bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sm_dbg_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sm_dbg_scan                                                                |
// | Walks regAddr then ramAddrB, streams each word out; SM_DBG_SCAN_CHKSUM_EN  |
// | appends a checksum word. Rev 1.0                                           |
// +----------------------------------------------------------------------------+
module sm_dbg_scan
   import sm_dbg_scan_pkg::*;
#(
   parameter int REG_CNT = 32,
   parameter int RAM_CNT = 16,
   parameter int RD_LAT  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [IDX_W-1:0]  regAddr,
   input  logic [DATA_W-1:0] regData,
   output logic [IDX_W-1:0]  ramAddrB,
   input  logic [DATA_W-1:0] ramDataB,
   sm_dbg_scan_if.master     stream
);

   generate
      if (REG_CNT < 1 || REG_CNT > 32 || RAM_CNT < 0 || RAM_CNT > 32 || RD_LAT < 1 || RD_LAT > 3) begin : g_bad_param
         $error("sm_dbg_scan: REG_CNT/RAM_CNT must be <= 32 and RD_LAT within 1..3");
      end
   endgenerate

   localparam logic [IDX_W-1:0] C_REG_LAST  = IDX_W'(REG_CNT - 1);
   localparam logic [IDX_W-1:0] C_RAM_LAST  = IDX_W'((RAM_CNT == 0) ? 0 : RAM_CNT - 1);
   localparam logic [1:0]       C_WAIT_LAST = 2'(RD_LAT - 1);
`ifdef SM_DBG_SCAN_CHKSUM_EN
   localparam logic [2:0]       C_AFTER_DATA = S_SUM;
`else
   localparam logic [2:0]       C_AFTER_DATA = S_FIN;
`endif

   logic [2:0]        r_state;
   logic [2:0]        w_state_nx;
   logic [IDX_W-1:0]  r_idx;
   kind_e             r_phase;
   logic [1:0]        r_wcnt;
   logic              w_last;
   logic              w_cap;
   logic              w_load;
   logic [TAG_W-1:0]  w_load_tag;
   logic [DATA_W-1:0] w_load_data;
   logic [DATA_W-1:0] w_word;
   logic [DATA_W-1:0] w_sum;

   assign w_last = (r_phase == K_REG) ? (r_idx == C_REG_LAST) :
                   (r_phase == K_RAM) ? (r_idx == C_RAM_LAST) : 1'b1;
   assign w_word = (r_phase == K_REG) ? regData : ramDataB;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE: if (start) w_state_nx = S_ADDR;
         S_ADDR: w_state_nx = S_WAIT;
         S_WAIT: if (r_wcnt == C_WAIT_LAST) w_state_nx = S_EMIT;
         S_EMIT: begin
            if (stream.out_ready) begin
               if (!w_last || (r_phase == K_REG && RAM_CNT > 0)) w_state_nx = S_ADDR;
               else if (r_phase == K_SUM)                         w_state_nx = S_FIN;
               else                                               w_state_nx = C_AFTER_DATA;
            end
         end
         S_SUM:   w_state_nx = S_EMIT;
         S_FIN:   w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      busy        = (r_state != S_IDLE) && (r_state != S_FIN);
      done        = (r_state == S_FIN);
      w_cap       = (r_state == S_WAIT) && (r_wcnt == C_WAIT_LAST);
      w_load      = w_cap || (r_state == S_SUM);
      w_load_tag  = make_tag(r_phase, r_idx);
      w_load_data = w_word;
      if (r_state == S_SUM) begin
         w_load_tag  = make_tag(K_SUM, '0);
         w_load_data = w_sum;
      end
   end

   // Address ports only change in ADDR, so the port not being scanned keeps its last value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx    <= '0;
         r_phase  <= K_REG;
         r_wcnt   <= '0;
         regAddr  <= '0;
         ramAddrB <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_idx   <= '0;
                  r_phase <= K_REG;
               end
            end
            S_ADDR: begin
               r_wcnt <= '0;
               if (r_phase == K_REG) regAddr  <= r_idx;
               else                  ramAddrB <= r_idx;
            end
            S_WAIT: r_wcnt <= r_wcnt + 2'd1;
            S_EMIT: begin
               if (stream.out_ready) begin
                  if (w_last) begin
                     r_idx <= '0;
                     if (r_phase == K_REG) r_phase <= K_RAM;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            S_SUM:   r_phase <= K_SUM;
            default: ;
         endcase
      end
   end

`ifdef SM_DBG_SCAN_CHKSUM_EN
   logic [DATA_W-1:0] r_sum;
   always_ff @(posedge clk) begin
      if (rst || r_state == S_IDLE) r_sum <= '0;
      else if (w_cap)               r_sum <= r_sum + w_word;
   end
   assign w_sum = r_sum;
`else
   assign w_sum = '0;
`endif

   sm_dbg_outreg u_outreg (
      .clk       (clk),
      .rst       (rst),
      .load      (w_load),
      .load_tag  (w_load_tag),
      .load_data (w_load_data),
      .bus       (stream)
   );

endmodule
`default_nettype wire

// File: tb/tb_sm_dbg_scan.sv
`default_nettype none
// Bench for sm_dbg_scan: randomized RF/RAM contents, expected word stream
// derived from the array contents and the per-word timing rules.
module tb_sm_dbg_scan;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start0 = 1'b0;
   logic        start1 = 1'b0;
   logic        rdy = 1'b1;
   bit          sel = 1'b0;
   logic        busy0, done0, busy1, done1;
   logic [4:0]  ra0, ma0, ra1, ma1;
   logic [31:0] rd0, md0, rd1, md1;
   logic [31:0] rf [32];
   logic [31:0] ram[32];
   int          checks = 0;
   int          failures = 0;

   sm_dbg_scan_if bus0();
   sm_dbg_scan_if bus1();
   assign bus0.out_ready = rdy;
   assign bus1.out_ready = rdy;
   assign rd0 = rf[ra0];
   assign md0 = ram[ma0];
   assign rd1 = rf[ra1];
   assign md1 = ram[ma1];

   sm_dbg_scan #(.REG_CNT(32), .RAM_CNT(16), .RD_LAT(1)) dut (
      .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
      .regAddr(ra0), .regData(rd0), .ramAddrB(ma0), .ramDataB(md0), .stream(bus0.master)
   );

   sm_dbg_scan #(.REG_CNT(32), .RAM_CNT(0), .RD_LAT(1)) dut_noram (
      .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
      .regAddr(ra1), .regData(rd1), .ramAddrB(ma1), .ramDataB(md1), .stream(bus1.master)
   );

   always #5 clk = ~clk;

   logic        s_valid, s_busy, s_done;
   logic [6:0]  s_tag;
   logic [31:0] s_data;
   assign s_valid = sel ? bus1.out_valid : bus0.out_valid;
   assign s_tag   = sel ? bus1.out_tag   : bus0.out_tag;
   assign s_data  = sel ? bus1.out_data  : bus0.out_data;
   assign s_busy  = sel ? busy1 : busy0;
   assign s_done  = sel ? done1 : done0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel) start1 = v;
      else     start0 = v;
   endtask

   task automatic fill_random();
      for (int i = 0; i < 32; i++) begin
         rf[i]  = $urandom;
         ram[i] = $urandom;
      end
   endtask

   // One full scan: expected stream is every register, then every RAM word, then the checksum.
   task automatic run_scan(input int nreg, input int nram, input bit bp);
      logic [6:0]  etag[$];
      logic [31:0] edat[$];
      logic [31:0] sum;
      int          cyc, last_hs, hs, hold, total;
      bit          held21, stall, fin;
      logic [6:0]  ptag, gtag;
      logic [31:0] pdat;
      sum = 0;
      for (int i = 0; i < nreg; i++) begin
         etag.push_back({2'b00, 5'(i)}); edat.push_back(rf[i]); sum += rf[i];
      end
      for (int j = 0; j < nram; j++) begin
         etag.push_back({2'b01, 5'(j)}); edat.push_back(ram[j]); sum += ram[j];
      end
`ifdef SM_DBG_SCAN_CHKSUM_EN
      etag.push_back(7'h40); edat.push_back(sum);
`endif
      total = etag.size();
      cyc = 1; last_hs = 0; hs = 0; hold = 0; held21 = 0; stall = 0; fin = 0;
      ptag = '0; pdat = '0;
      rdy = 1'b1;
      @(negedge clk); set_start(1'b1);
      @(negedge clk); set_start(1'b0);
      while (!fin && cyc < 2000) begin
         set_start(cyc == 10);
         if (bp) begin
            if (s_valid && s_tag == 7'h21 && !held21) begin
               hold = 5; held21 = 1'b1;
            end
            if (hold > 0) begin
               rdy = 1'b0; hold--;
            end else begin
               rdy = ($urandom_range(0, 3) != 0);
            end
         end else begin
            rdy = 1'b1;
         end
         #1;
         if (stall) begin
            chk("hold_valid", s_valid, 1'b1);
            chk("hold_tag",   s_tag,   ptag);
            chk("hold_data",  s_data,  pdat);
         end
         if (s_done) begin
            fin = 1'b1;
            chk("word_count",   hs, total);
            chk("done_latency", cyc - last_hs, 1);
            chk("busy_at_done", s_busy, 1'b0);
         end else if (s_valid && rdy) begin
            hs++;
            if (etag.size() == 0) begin
               chk("extra_word", s_tag, 7'h7f);
            end else begin
               gtag = etag.pop_front();
               chk("word_tag",  s_tag,  gtag);
               chk("word_data", s_data, edat.pop_front());
               if (!bp) chk("word_interval", cyc - last_hs, (gtag[6:5] == 2'b10) ? 2 : 3);
            end
            last_hs = cyc;
         end
         stall = s_valid && !rdy;
         ptag = s_tag; pdat = s_data;
         @(negedge clk);
         cyc++;
      end
      set_start(1'b0);
      rdy = 1'b1;
      if (!fin) chk("scan_timeout", cyc, 0);
      repeat (4) @(negedge clk);
      chk("no_rescan", {s_busy, s_valid}, 2'b00);
   endtask

   initial begin
      int n;
      fill_random();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_busy",  busy0, 1'b0);
      chk("rst_done",  done0, 1'b0);
      chk("rst_valid", bus0.out_valid, 1'b0);
      chk("rst_tag",   bus0.out_tag, 7'h00);
      chk("rst_data",  bus0.out_data, 32'h0);
      chk("rst_addr",  {ra0, ma0}, 10'h0);
      chk("rst_noram", {busy1, done1, bus1.out_valid}, 3'b000);
      @(negedge clk); rst = 1'b0;

      // Free-flowing scan with two known registers.
      rf[2] = 32'd5; rf[3] = 32'd7;
      sel = 1'b0;
      run_scan(32, 16, 1'b0);

      // Random backpressure with a 5-cycle stall on ram[1].
      fill_random();
      ram[1] = 32'h1234;
      run_scan(32, 16, 1'b1);

      // Variant without a RAM phase.
      fill_random();
      sel = 1'b1;
      run_scan(32, 0, 1'b0);

      // Reset while word 10 is presented, then a clean rescan.
      sel = 1'b0;
      rdy = 1'b1;
      @(negedge clk); start0 = 1'b1;
      @(negedge clk); start0 = 1'b0;
      n = 0;
      while (!(bus0.out_valid && bus0.out_tag == 7'h0A) && n < 200) begin
         @(negedge clk); n++;
      end
      chk("reach_word10", (n < 200), 1'b1);
      rdy = 1'b0; rst = 1'b1;
      @(negedge clk); #1;
      chk("midrst_valid", bus0.out_valid, 1'b0);
      chk("midrst_busy",  busy0, 1'b0);
      chk("midrst_tag",   bus0.out_tag, 7'h00);
      rst = 1'b0; rdy = 1'b1;
      @(negedge clk);
      run_scan(32, 16, 1'b0);

`ifdef SM_DBG_SCAN_CHKSUM_EN
      for (int i = 0; i < 32; i++) begin
         rf[i] = 32'd1; ram[i] = 32'd2;
      end
      run_scan(32, 16, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
